// File: rtl/fp_normalize_round_pkg.sv
// Shared types and constants for the floating-point normalize/round/pack stage.
// Operands arrive as significand * 2^(exponent - FP_EXP_REBIAS) with the hidden bit at bit 26.
package fp_normalize_round_pkg;

  localparam int VECTOR_LANES = 4;

  typedef logic [1:0] thread_idx_t;
  typedef logic [3:0] subcycle_t;

  typedef enum logic [3:0] {
    OP_FADD = 4'd0,
    OP_FSUB = 4'd1,
    OP_FMUL = 4'd2,
    OP_ITOF = 4'd3,
    OP_FTOI = 4'd4,
    OP_IMUL = 4'd5,
    OP_IADD = 4'd6,
    OP_MOVE = 4'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       has_dest;
    logic [4:0] dest_reg;
    logic       is_vector;
  } decoded_instruction_t;

  localparam int          FP_SIG_HIDDEN_BIT = 26;
  localparam int          FP_EXP_REBIAS     = 153;
  localparam logic [31:0] FP_CANONICAL_NAN  = 32'h7fc00000;

  // Per-lane record held between the leading-one search and the round/pack step.
  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              inf;
    logic              zero;
    logic [4:0]        msb;
    logic signed [9:0] expo;
    logic [31:0]       sig;
  } nr_lane_t;

  function automatic logic op_is_rounded(alu_op_t op);
    return op inside {OP_FADD, OP_FSUB, OP_ITOF, OP_FMUL};
  endfunction

endpackage

// File: rtl/fp_normalize_round_if.sv
// Upstream (mx_*) operand bundle and downstream (nr_*) result bundle of the pack stage.
interface fp_normalize_round_if
  import fp_normalize_round_pkg::*;
#(
  parameter int LANES = VECTOR_LANES
);

  logic                   mx_instruction_valid;
  decoded_instruction_t   mx_instruction;
  thread_idx_t            mx_thread_idx;
  logic [LANES-1:0]       mx_mask_value;
  subcycle_t              mx_subcycle;
  logic [LANES-1:0]       mx_result_is_nan;
  logic [LANES-1:0]       mx_result_is_inf;
  logic [LANES-1:0]       mx_sign;
  logic [LANES-1:0][7:0]  mx_exponent;
  logic [LANES-1:0][31:0] mx_significand;

  logic                   nr_instruction_valid;
  decoded_instruction_t   nr_instruction;
  thread_idx_t            nr_thread_idx;
  logic [LANES-1:0]       nr_mask_value;
  subcycle_t              nr_subcycle;
  logic [LANES-1:0][31:0] nr_result;

  modport master (
    output mx_instruction_valid, mx_instruction, mx_thread_idx, mx_mask_value, mx_subcycle,
    output mx_result_is_nan, mx_result_is_inf, mx_sign, mx_exponent, mx_significand,
    input  nr_instruction_valid, nr_instruction, nr_thread_idx, nr_mask_value, nr_subcycle,
    input  nr_result
  );

  modport slave (
    input  mx_instruction_valid, mx_instruction, mx_thread_idx, mx_mask_value, mx_subcycle,
    input  mx_result_is_nan, mx_result_is_inf, mx_sign, mx_exponent, mx_significand,
    output nr_instruction_valid, nr_instruction, nr_thread_idx, nr_mask_value, nr_subcycle,
    output nr_result
  );

endinterface

// File: rtl/fp_normalize_round_lzc.sv
// 32-bit leading-one detector: index of the highest set bit, plus an all-zero flag.
module fp_lzc (
  input  logic [31:0] value_i,
  output logic [4:0]  index_o,
  output logic        zero_o
);

  always_comb begin
    index_o = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (value_i[i]) index_o = 5'(i);
    end
  end

  assign zero_o = ~|value_i;

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalize / round-to-nearest-even / pack to binary32, with per-thread rollback squash.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
#(
  parameter int LANES = VECTOR_LANES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_rollback_en,
  input  thread_idx_t         wb_rollback_thread_idx,
  fp_normalize_round_if.slave bus
);

  localparam logic [4:0] HiddenIdx = 5'(FP_SIG_HIDDEN_BIT);
  localparam int         ExpAdjust = FP_EXP_REBIAS - 127;

  logic [LANES-1:0][4:0]  lzc_idx;
  logic [LANES-1:0]       lzc_zero;
  nr_lane_t [LANES-1:0]   s1_lane_d, s1_lane_q;
  logic                   s1_valid_q;
  decoded_instruction_t   s1_inst_q;
  thread_idx_t            s1_tid_q;
  logic [LANES-1:0]       s1_mask_q;
  subcycle_t              s1_sub_q;
  logic                   s1_kill, s2_kill;

  logic [LANES-1:0][31:0] res_d;
  logic                   nr_valid_q;
  decoded_instruction_t   nr_inst_q;
  thread_idx_t            nr_tid_q;
  logic [LANES-1:0]       nr_mask_q;
  subcycle_t              nr_sub_q;
  logic [LANES-1:0][31:0] nr_result_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lzc
    fp_lzc u_lzc (
      .value_i (bus.mx_significand[l]),
      .index_o (lzc_idx[l]),
      .zero_o  (lzc_zero[l])
    );
  end

  // e' = biased binary32 exponent of the leading one; 10-bit signed so it never wraps.
  always_comb begin
    s1_lane_d = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      s1_lane_d[l].sign = bus.mx_sign[l];
      s1_lane_d[l].nan  = bus.mx_result_is_nan[l];
      s1_lane_d[l].inf  = bus.mx_result_is_inf[l];
      s1_lane_d[l].zero = lzc_zero[l];
      s1_lane_d[l].msb  = lzc_idx[l];
      s1_lane_d[l].sig  = bus.mx_significand[l];
      s1_lane_d[l].expo = $signed({2'b00, bus.mx_exponent[l]}) + $signed({5'b0, lzc_idx[l]})
                          - $signed(10'(ExpAdjust));
    end
  end

  assign s1_kill = wb_rollback_en && (wb_rollback_thread_idx == bus.mx_thread_idx);
  assign s2_kill = wb_rollback_en && (wb_rollback_thread_idx == s1_tid_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_inst_q  <= '0;
      s1_tid_q   <= '0;
      s1_mask_q  <= '0;
      s1_sub_q   <= '0;
      s1_lane_q  <= '0;
    end else begin
      s1_valid_q <= bus.mx_instruction_valid && !s1_kill;
      s1_inst_q  <= bus.mx_instruction;
      s1_tid_q   <= bus.mx_thread_idx;
      s1_mask_q  <= bus.mx_mask_value;
      s1_sub_q   <= bus.mx_subcycle;
      s1_lane_q  <= s1_lane_d;
    end
  end

  // Bits shifted out on a right normalize fold into the sticky bit so rounding stays exact.
  function automatic logic [31:0] pack_lane(nr_lane_t r);
    logic [4:0]        sh;
    logic [31:0]       lost;
    logic [26:0]       norm;
    logic              inc;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic signed [9:0] e;
    logic [31:0]       res;
    sh   = '0;
    lost = '0;
    if (r.msb > HiddenIdx) begin
      sh   = r.msb - HiddenIdx;
      lost = r.sig & ((32'd1 << sh) - 32'd1);
      norm = 27'(r.sig >> sh) | {26'd0, |lost};
    end else begin
      norm = 27'(r.sig << (HiddenIdx - r.msb));
    end
    inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
    sum  = {1'b0, norm[26:3]} + {24'd0, inc};
    e    = sum[24] ? r.expo + 10'sd1 : r.expo;
    frac = sum[24] ? sum[23:1] : sum[22:0];
    if (r.nan) begin
      res = FP_CANONICAL_NAN;
    end else if (r.inf || (e >= 10'sd255)) begin
      res = {r.sign, 8'hff, 23'd0};
    end else if (r.zero) begin
      res = '0;
    end else if (e <= 10'sd0) begin
      res = {r.sign, 31'd0};
    end else begin
      res = {r.sign, e[7:0], frac};
    end
    return res;
  endfunction

  always_comb begin
    res_d = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      res_d[l] = op_is_rounded(s1_inst_q.alu_op) ? pack_lane(s1_lane_q[l]) : s1_lane_q[l].sig;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nr_valid_q  <= 1'b0;
      nr_inst_q   <= '0;
      nr_tid_q    <= '0;
      nr_mask_q   <= '0;
      nr_sub_q    <= '0;
      nr_result_q <= '0;
    end else begin
      nr_valid_q  <= s1_valid_q && !s2_kill;
      nr_inst_q   <= s1_inst_q;
      nr_tid_q    <= s1_tid_q;
      nr_mask_q   <= s1_mask_q;
      nr_sub_q    <= s1_sub_q;
      nr_result_q <= res_d;
    end
  end

  assign bus.nr_instruction_valid = nr_valid_q;
  assign bus.nr_instruction       = nr_inst_q;
  assign bus.nr_thread_idx        = nr_tid_q;
  assign bus.nr_mask_value        = nr_mask_q;
  assign bus.nr_subcycle          = nr_sub_q;
  assign bus.nr_result            = nr_result_q;

endmodule

// File: doc/fp_normalize_round.md
# fp_normalize_round

Final stage of the multi-cycle floating-point pipeline. It is the consumer of the unpacked sign/exponent/significand form that the front stages produce, and it packs results back into IEEE 754 binary32. Per lane it finds the leading one, normalizes, rounds to nearest-even, detects overflow and underflow, and packs the word. It is a two-stage pipeline with no stall, with per-thread rollback squash, and it sits directly ahead of writeback.

## Interface
Parameters:
- LANES, default `VECTOR_LANES: number of vector lanes.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wb_rollback_en  in  1  rollback request from writeback.
- wb_rollback_thread_idx  in  thread_idx_t  thread being rolled back.
- mx_instruction_valid  in  1  input is valid.
- mx_instruction  in  decoded_instruction_t  carried through; alu_op selects the behaviour.
- mx_thread_idx  in  thread_idx_t  carried through.
- mx_mask_value  in  LANES  carried through.
- mx_subcycle  in  subcycle_t  carried through.
- mx_result_is_nan  in  LANES  per-lane NaN flag from upstream.
- mx_result_is_inf  in  LANES  per-lane infinity flag from upstream.
- mx_sign  in  LANES  result sign.
- mx_exponent  in  LANES×8  biased exponent.
- mx_significand  in  LANES×32  unnormalized magnitude.
- nr_instruction_valid, nr_instruction, nr_thread_idx, nr_mask_value, nr_subcycle  out  same widths as the inputs  delayed copies.
- nr_result  out  LANES×32  packed result.

## Operation
Value encoding and handled operations:
- Input value = significand × 2^(exponent − 153).
  - Bit 26 is the hidden bit position.
  - Bits 2/1/0 are guard/round/sticky.
  - ITOF supplies the integer magnitude with exponent = 153.
- alu_op FADD, FSUB, ITOF, FMUL: normalized and rounded.
- Any other alu_op: nr_result = mx_significand unchanged (pass-through for FTOI and IMUL).

Stage 1 (leading-zero count):
- p = index of the most significant set bit of the significand.
- Register the significand, p, and e' = exponent + p − 26. e' is 10-bit signed and must not wrap.
- Register a zero flag (significand == 0), sign, nan, inf, and all sideband fields.

Stage 2 (shift, round, pack):
- Normalize the significand:
  - If p > 26, shift right by p − 26. Every bit shifted out ORs into the sticky bit (bit 0).
  - If p < 26, shift left by 26 − p.
- Round to nearest-even:
  - Increment at bit 3 when guard && (round || sticky || bit3).
  - If rounding carries into bit 27, shift right by 1 and do e' += 1.
- Pack, in priority order:
  1. nan → 32'h7fc00000.
  2. inf, or e' ≥ 255 → {sign, 8'hff, 23'd0}.
  3. zero flag → 32'h00000000.
  4. e' ≤ 0 → {sign, 31'd0}. Flush to zero; no subnormals are produced.
  5. Otherwise → {sign, e'[7:0], significand[25:3]}.

Rollback squash:
- The stage-1 valid register loads mx_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == mx_thread_idx).
- The stage-2 valid register loads the same expression evaluated on the stage-1 valid and thread index.
- Data registers load unconditionally, regardless of valid.

## Timing
- Latency: exactly 2 cycles from input to nr_*. Throughput: one instruction per cycle. No backpressure.
- Reset (synchronous):
  - All valid bits go to 0.
  - nr_instruction, nr_thread_idx, nr_mask_value, nr_subcycle and nr_result go to 0.
  - If reset is asserted mid-stream, both in-flight instructions are dropped. nr_instruction_valid is 0 in the cycle after reset is sampled.
- Simultaneous events:
  - A rollback for thread T squashes every stage holding T in that cycle.
  - Other threads proceed undisturbed.
  - A new T instruction presented on the cycle after the rollback is accepted.
- Lanes with mask = 0 are still computed; the mask is only carried through.

## Structure
- Add to defines.v / the shared package:
  - FP_SIG_HIDDEN_BIT (26).
  - FP_EXP_REBIAS (153).
  - FP_CANONICAL_NAN (32'h7fc00000).
  - A packed typedef for the stage-1 per-lane record.
- Sub-module fp_lzc: a 32-bit leading-one detector, purely combinational, outputting a 5-bit index and an all-zero flag. Instantiate one per lane in a generate loop.

## Test plan
- sig = 1<<26, exp = 127, sign = 0, FADD → nr_result = 32'h3f800000, two cycles later.
- sig = 1<<27, exp = 127 → 32'h40000000. sig = (1<<26)|4'b1100 → 32'h3f800002 (round up on odd LSB). sig = (1<<26)|4'b0100 → 32'h3f800000 (tie to even).
- ITOF: sig = 7, exp = 153 → 32'h40e00000. sig = 0 → 32'h00000000.
- sig = 1<<27, exp = 254 → 32'h7f800000. sig = 1<<26, exp = 0, sign = 1 → 32'h80000000. mx_result_is_nan = 1 → 32'h7fc00000 regardless of other inputs.
- Back-to-back thread-0 and thread-1 instructions, with a rollback for thread 0 one cycle later → only the thread-1 result appears with nr_instruction_valid = 1.
- Reset asserted while two instructions are in flight → nr_instruction_valid = 0 and nr_result = 0 on the following cycles. Pass-through op: alu_op = OP_IMUL, sig = 32'hdeadbeef → nr_result = 32'hdeadbeef.
